odd_parity_frame_checker: RTL and testbench
===========================================

Name: odd_parity_frame_checker

Overview:
Receive-side partner of the 4-bit odd parity generator. Deserialises a frame of DATA_W data bits followed by one odd-parity bit, presents the recovered word, and flags a parity error. A saturating error counter supports link-quality monitoring. Sits at the receive end of any serial path whose transmit side appends generator output y.

Parameters:
DATA_W, 4, number of data bits per frame (>=2)
CNT_W, 8, width of saturating parity-error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  serial bit, sampled only when bit_valid=1
bit_valid  input  1  qualifies bit_in for the current cycle
abort  input  1  synchronous frame abort, discards partial frame
clr_err_cnt  input  1  synchronous clear of err_cnt
data_out  output  DATA_W  last received data word, b(DATA_W-1) first on the wire
parity_err  output  1  error status of last completed frame
frame_done  output  1  one-cycle pulse: data_out/parity_err updated
busy  output  1  high while a frame is partially received
err_cnt  output  CNT_W  count of frames with parity error, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit counter=0, shift reg=0, running xor=0; data_out=0, parity_err=0, frame_done=0, busy=0, err_cnt=0. Reset mid-frame discards the partial frame; no frame_done.
- Wire order: data MSB first (b3,b2,b1,b0 for DATA_W=4), then parity bit. Cycles with bit_valid=0 are ignored (gaps allowed anywhere, including between last data bit and parity).
- Odd parity rule: frame valid when XOR of all DATA_W data bits and parity bit = 1; parity_err = ~(xor of data ^ parity).
- FSM:
  - IDLE: busy=0. bit_valid=1 -> capture bit as MSB, xor=bit_in, cnt=1, go DATA (or PARITY if DATA_W=1 — not allowed).
  - DATA: busy=1. Each valid bit shifts in LSB-ward, xor^=bit_in, cnt++. When cnt reaches DATA_W after accepting bit, go PARITY.
  - PARITY: busy=1. Valid bit = parity bit; compute error; go IDLE.
- Output timing: registered. In the cycle after the parity bit is accepted: frame_done=1 for exactly one cycle, data_out=received word, parity_err=computed flag. data_out and parity_err hold until next frame_done.
- Back-to-back: a valid bit in the cycle frame_done is high (i.e. FSM in IDLE) starts the next frame; no dead cycle required.
- abort=1: state->IDLE, cnt/shift/xor cleared, no frame_done; outputs data_out/parity_err/err_cnt unchanged. abort takes priority over bit_valid in same cycle (bit dropped). abort in IDLE is a no-op.
- err_cnt: increments on the cycle frame_done rises with parity_err=1; saturates at 2^CNT_W-1. clr_err_cnt=1 sets err_cnt=0; clear wins over a simultaneous increment (result 0).
- No combinational path from inputs to outputs.

Test Plan:
- Reset then send 1,0,1,1 + parity 0 with bit_valid continuous -> one cycle after parity: frame_done=1, data_out=4'b1011, parity_err=0, err_cnt=0.
- Send 0,1,1,0 + parity 0 with bit_valid toggling 1/0 every cycle -> data_out=4'b0110, parity_err=1, err_cnt=1; busy high from first bit to parity acceptance.
- Back-to-back frames 0000/p=1 then 1111/p=1 with no gap -> two frame_done pulses 5 cycles apart; data_out 0000 then 1111, parity_err 0 both times.
- Send 1,1,0 then abort=1 with bit_valid=1 same cycle -> busy drops next cycle, no frame_done, data_out unchanged; following frame 0001/p=0 decodes correctly, parity_err=0.
- Drive 256 erroneous frames (0000/p=0) -> err_cnt holds 255; pulse clr_err_cnt coincident with an error frame_done -> err_cnt=0.
- Assert rst_n=0 asynchronously after 2 data bits -> all outputs 0 immediately; after release, frame 1001/p=1 -> data_out=4'b1001, parity_err=0.

Source files
------------

// File: rtl/odd_parity_frame_checker.sv
// Receive-side odd parity frame checker: deserialises DATA_W data bits (MSB first) plus
// one odd-parity bit, reports the word, a parity error flag and a saturating error count.
module odd_parity_frame_checker #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              abort,
  input  logic              clr_err_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              frame_done,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam logic [BitCntW-1:0] LastDataIdx = BitCntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e              state_q;
  logic [BitCntW-1:0]  cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                xor_q;

  logic                parity_accept;
  logic                frame_err;

  always_comb begin
    parity_accept = 1'b0;
    frame_err     = 1'b0;
    if (!abort && bit_valid && (state_q == StParity)) begin
      parity_accept = 1'b1;
    end
    // Odd parity: data xor parity must be 1 for a good frame.
    frame_err = ~(xor_q ^ bit_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      xor_q      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        shift_q <= '0;
        xor_q   <= 1'b0;
        busy    <= 1'b0;
      end else if (bit_valid) begin
        unique case (state_q)
          StIdle: begin
            shift_q <= {{(DATA_W-1){1'b0}}, bit_in};
            xor_q   <= bit_in;
            cnt_q   <= BitCntW'(1);
            state_q <= StData;
            busy    <= 1'b1;
          end
          StData: begin
            shift_q <= {shift_q[DATA_W-2:0], bit_in};
            xor_q   <= xor_q ^ bit_in;
            cnt_q   <= cnt_q + BitCntW'(1);
            if (cnt_q == LastDataIdx) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            data_out   <= shift_q;
            parity_err <= frame_err;
            frame_done <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StIdle;
            busy       <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end

      // Clear beats a coincident increment.
      if (clr_err_cnt) begin
        err_cnt <= '0;
      end else if (parity_accept && frame_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_odd_parity_frame_checker.sv
// Scoreboard bench for odd_parity_frame_checker: expected frames are queued as they are
// driven and compared when frame_done pulses.
module tb_odd_parity_frame_checker;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              abort = 1'b0;
  logic              clr_err_cnt = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              parity_err;
  logic              frame_done;
  logic              busy;
  logic [CNT_W-1:0]  err_cnt;

  int unsigned n_tests = 0;
  int unsigned n_failed = 0;
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;
  int unsigned prev_done_cyc = 0;
  int unsigned model_cnt = 0;
  exp_t        sb[$];

  odd_parity_frame_checker #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .abort      (abort),
    .clr_err_cnt(clr_err_cnt),
    .data_out   (data_out),
    .parity_err (parity_err),
    .frame_done (frame_done),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every frame_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && frame_done === 1'b1) begin
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    idle(gap);
  endtask

  task automatic send_data(input logic [DATA_W-1:0] d, input int gap);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i], gap);
  endtask

  // Queue the expectation, then drive the parity bit (optionally with a counter clear).
  task automatic send_parity(input logic [DATA_W-1:0] d, input logic p, input logic clr,
                             input int gap);
    exp_t e;
    e.data = d;
    e.perr = ~((^d) ^ p);
    if (clr) model_cnt = 0;
    else if (e.perr && model_cnt < 255) model_cnt++;
    e.cnt = CNT_W'(model_cnt);
    sb.push_back(e);
    clr_err_cnt = clr;
    send_bit(p, 0);
    clr_err_cnt = 1'b0;
    idle(gap);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input int gap);
    send_data(d, gap);
    send_parity(d, p, 1'b0, gap);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Good frame, continuous valid.
    send_frame(4'b1011, 1'b0, 0);
    idle(2);

    // Bad frame with bit_valid toggling; busy spans first bit to parity acceptance.
    send_bit(1'b0, 1);
    check("busy_after_first", 32'(busy), 32'd1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    check("busy_before_parity", 32'(busy), 32'd1);
    send_parity(4'b0110, 1'b0, 1'b0, 0);
    check("busy_after_parity", 32'(busy), 32'd0);
    check("done_after_parity", 32'(frame_done), 32'd1);
    idle(2);

    // Back-to-back frames, pulses five cycles apart.
    send_frame(4'b0000, 1'b1, 0);
    send_frame(4'b1111, 1'b1, 0);
    idle(1);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd5);
    idle(2);

    // Abort with a simultaneous valid bit drops the bit and the partial frame.
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    abort = 1'b1;
    send_bit(1'b1, 0);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(frame_done), 32'd0);
    check("abort_data_hold", 32'(data_out), 32'hF);
    idle(3);
    check("abort_still_no_done", 32'(sb.size()), 32'd0);
    send_frame(4'b0001, 1'b0, 0);
    idle(2);

    // Saturation, then clear coincident with an error increment.
    for (int k = 0; k < 256; k++) send_frame(4'b0000, 1'b0, 0);
    idle(2);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    send_data(4'b0000, 0);
    send_parity(4'b0000, 1'b0, 1'b1, 0);
    idle(2);
    check("err_cnt_cleared", 32'(err_cnt), 32'd0);

    // Async reset mid-frame clears everything immediately.
    send_frame(4'b1010, 1'b0, 0);
    idle(1);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_parity_err", 32'(parity_err), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send_frame(4'b1001, 1'b1, 0);
    idle(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
